// File: rtl/rfsoc_cap_pkg.sv
// Shared definitions for the RFSoC capture path: framer state encoding,
// beat/burst geometry helpers and the S2MM command-generator constants.
package rfsoc_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } cap_state_e;

  // Command-generator fields; the framer's burst split must match these bursts.
  localparam int   CMD_BTT_W     = 23;
  localparam logic CMD_TYPE_INCR = 1'b1;
  localparam logic CMD_EOF       = 1'b1;

  function automatic int bytes_per_beat(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int burst_beats(input int data_width, input int max_burst_len);
    return max_burst_len / bytes_per_beat(data_width);
  endfunction

  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream skid buffer; the head entry drives the outputs directly,
// so output data is registered and held until the consumer takes it.
module axis_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             empty
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign empty     = (cnt_q == 2'd0);
  assign out_data  = head_q;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    push   = in_valid && (cnt_q != 2'd2);
    pop    = out_ready && (cnt_q != 2'd0);
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case (cnt_q)
        2'd0: begin
          if (push) begin
            head_d = in_data;
            cnt_d  = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_d = in_data;
          end else if (push) begin
            tail_d = in_data;
            cnt_d  = 2'd2;
          end else if (pop) begin
            cnt_d = 2'd0;
          end
        end
        2'd2: begin
          // Full: no push possible, a pop promotes the skid entry.
          if (pop) begin
            head_d = tail_q;
            cnt_d  = 2'd1;
          end
        end
        default: cnt_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/axis_s2mm_data_framer.sv
// Frames a free-running ADC stream into DataMover S2MM bursts of cap_size bytes,
// marking tlast on each burst boundary the command generator will issue.
module axis_s2mm_data_framer
  import rfsoc_cap_pkg::*;
#(
  parameter int DATA_WIDTH    = 128,
  parameter int MAX_BURST_LEN = 512
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  input  logic                    write_start,
  input  logic                    write_reset,
  input  logic [31:0]             cap_size,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);

  localparam int          BPB         = bytes_per_beat(DATA_WIDTH);
  localparam int          BURST_BEATS = burst_beats(DATA_WIDTH, MAX_BURST_LEN);
  localparam int          SHIFT       = $clog2(BPB);
  localparam logic [31:0] BB_U        = 32'(BURST_BEATS);

  cap_state_e  state_q, state_d;
  logic [31:0] remaining_q, remaining_d;
  logic [31:0] burst_cnt_q, burst_cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        overflow_q, overflow_d;

  logic [31:0]         total_beats;
  logic                push;
  logic                buf_ready, buf_empty, buf_valid;
  logic [DATA_WIDTH:0] buf_out;

  assign total_beats = cap_size >> SHIFT;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    burst_cnt_d = burst_cnt_q;
    overflow_d  = overflow_q;
    push        = 1'b0;
    if (write_reset) begin
      state_d     = ST_IDLE;
      remaining_d = 32'd0;
      burst_cnt_d = 32'd0;
    end else begin
      if (write_start && !busy_q) overflow_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (write_start) begin
            if (total_beats != 32'd0) begin
              remaining_d = total_beats;
              burst_cnt_d = min_u32(total_beats, BB_U) - 32'd1;
              state_d     = ST_STREAM;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_STREAM: begin
          if (s_axis_tvalid) begin
            if (buf_ready) begin
              push        = 1'b1;
              remaining_d = remaining_q - 32'd1;
              // Reload for the next burst; after the final beat there is none.
              if (burst_cnt_q == 32'd0)
                burst_cnt_d = (remaining_q > 32'd1) ? min_u32(remaining_q - 32'd1, BB_U) - 32'd1 : 32'd0;
              else
                burst_cnt_d = burst_cnt_q - 32'd1;
              if (remaining_q == 32'd1) state_d = ST_DRAIN;
            end else begin
              overflow_d = 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (buf_empty) state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d == ST_STREAM) || (state_d == ST_DRAIN);
    done_d = (state_q == ST_DONE) && !write_reset;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      remaining_q <= 32'd0;
      burst_cnt_q <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      burst_cnt_q <= burst_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

  axis_skid_buf #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (write_reset),
    .in_valid (push),
    .in_ready (buf_ready),
    .in_data  ({(burst_cnt_q == 32'd0), s_axis_tdata}),
    .out_valid(buf_valid),
    .out_ready(m_axis_tready),
    .out_data (buf_out),
    .empty    (buf_empty)
  );

  // IDLE sinks the free-running stream so the ADC never backs up between captures.
  assign s_axis_tready = resetn && ((state_q == ST_IDLE) || ((state_q == ST_STREAM) && buf_ready));
  assign m_axis_tvalid = buf_valid;
  assign m_axis_tdata  = buf_out[DATA_WIDTH-1:0];
  assign m_axis_tlast  = buf_out[DATA_WIDTH];
  assign m_axis_tkeep  = '1;
  assign busy          = busy_q;
  assign done          = done_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_axis_s2mm_data_framer.sv
// Directed bench for axis_s2mm_data_framer: table of captures plus hand-written
// reset sequences; source data is a counter so dropped beats are visible.
module tb_axis_s2mm_data_framer;

  localparam int DW = 128;
  localparam int BB = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [DW/8-1:0] m_axis_tkeep;
  logic          write_start;
  logic          write_reset;
  logic [31:0]   cap_size;
  logic          busy;
  logic          done;
  logic          overflow;

  always #5 clk = ~clk;

  axis_s2mm_data_framer #(
    .DATA_WIDTH(DW),
    .MAX_BURST_LEN(512)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tkeep (m_axis_tkeep),
    .write_start  (write_start),
    .write_reset  (write_reset),
    .cap_size     (cap_size),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow)
  );

  typedef struct {
    int    cap;
    int    beats;
    int    stall_at;
    int    abort_at;
    int    ovf;
    string name;
  } vec_t;

  int            total = 0;
  int            bad   = 0;
  logic [31:0]   src_cnt;
  logic [DW-1:0] exp_q[$];
  vec_t          vecs[8];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    src_cnt++;
    s_axis_tdata = {4{src_cnt}};
  endtask

  task automatic run_cap(input vec_t v);
    int beats = 0, done_cnt = 0, done_cyc = -1, want = 0, stall_left = 5;
    bit busy_seen = 0, prev_stall = 0, abort_pend = 0, aborted = 0;
    logic [DW-1:0] pdata, expd;
    logic plast, exp_last;
    exp_q.delete();
    cap_size    = v.cap;
    write_start = 1'b1;
    step();
    write_start = 1'b0;
    want = v.beats;
    for (int cyc = 0; cyc < v.beats + 80; cyc++) begin
      if (abort_pend) begin
        check({v.name, "_abort_tvalid"}, DW'(m_axis_tvalid), DW'(0));
        check({v.name, "_abort_busy"}, DW'(busy), DW'(0));
        write_reset = 1'b0;
        abort_pend  = 0;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (busy) busy_seen = 1;
      if (prev_stall) begin
        check({v.name, "_hold_valid"}, DW'(m_axis_tvalid), DW'(1));
        check({v.name, "_hold_data"}, m_axis_tdata, pdata);
        check({v.name, "_hold_last"}, DW'(m_axis_tlast), DW'(plast));
      end
      if (v.stall_at > 0 && beats == v.stall_at && stall_left > 0) begin
        m_axis_tready = 1'b0;
        stall_left--;
      end else begin
        m_axis_tready = 1'b1;
      end
      prev_stall = 0;
      if (m_axis_tvalid && m_axis_tready) begin
        beats++;
        expd = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check({v.name, "_data"}, m_axis_tdata, expd);
        exp_last = ((beats % BB) == 0) || (beats == v.beats);
        check({v.name, "_tlast"}, DW'(m_axis_tlast), DW'(exp_last));
      end else if (m_axis_tvalid) begin
        prev_stall = 1;
        pdata      = m_axis_tdata;
        plast      = m_axis_tlast;
      end
      if (s_axis_tvalid && s_axis_tready && want > 0) begin
        exp_q.push_back(s_axis_tdata);
        want--;
      end
      if (v.abort_at > 0 && beats == v.abort_at && !aborted) begin
        write_reset = 1'b1;
        aborted     = 1;
        abort_pend  = 1;
        want        = 0;
        prev_stall  = 0;
      end
      step();
    end
    m_axis_tready = 1'b1;
    check({v.name, "_beats"}, DW'(beats), DW'((v.abort_at > 0) ? v.abort_at : v.beats));
    check({v.name, "_done_cnt"}, DW'(done_cnt), DW'((v.abort_at > 0) ? 0 : 1));
    check({v.name, "_overflow"}, DW'(overflow), DW'(v.ovf));
    if (v.cap == 0) begin
      check({v.name, "_done_cycle"}, DW'(done_cyc), DW'(1));
      check({v.name, "_busy_seen"}, DW'(busy_seen), DW'(0));
    end else begin
      check({v.name, "_busy_seen"}, DW'(busy_seen), DW'(1));
    end
  endtask

  initial begin
    resetn        = 1'b0;
    s_axis_tvalid = 1'b1;
    src_cnt       = 32'd0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    write_start   = 1'b0;
    write_reset   = 1'b0;
    cap_size      = 32'd0;

    vecs[0] = '{2048, 128, 0,  0,  0, "c2048"};
    vecs[1] = '{600,  37,  0,  0,  0, "c600"};
    vecs[2] = '{0,    0,   0,  0,  0, "c0"};
    vecs[3] = '{2048, 128, 40, 0,  1, "stall"};
    vecs[4] = '{2048, 128, 0,  10, 0, "abort"};
    vecs[5] = '{512,  32,  0,  0,  0, "c512"};
    vecs[6] = '{31,   1,   0,  0,  0, "c31"};
    vecs[7] = '{528,  33,  0,  0,  0, "c528"};

    repeat (3) step();
    check("rst_s_tready", DW'(s_axis_tready), DW'(0));
    check("rst_m_tvalid", DW'(m_axis_tvalid), DW'(0));
    check("rst_m_tlast", DW'(m_axis_tlast), DW'(0));
    check("rst_m_tdata", m_axis_tdata, DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    check("rst_overflow", DW'(overflow), DW'(0));
    check("tkeep", DW'(m_axis_tkeep), DW'(16'hffff));
    resetn = 1'b1;
    step();
    check("idle_s_tready", DW'(s_axis_tready), DW'(1));
    check("idle_m_tvalid", DW'(m_axis_tvalid), DW'(0));

    for (int i = 0; i < 8; i++) run_cap(vecs[i]);

    // Reset in the middle of a stalled stream.
    m_axis_tready = 1'b0;
    cap_size      = 32'd2048;
    write_start   = 1'b1;
    step();
    write_start = 1'b0;
    repeat (10) step();
    check("mid_busy", DW'(busy), DW'(1));
    check("mid_overflow", DW'(overflow), DW'(1));
    check("mid_m_tvalid", DW'(m_axis_tvalid), DW'(1));
    resetn = 1'b0;
    step();
    check("mrst_s_tready", DW'(s_axis_tready), DW'(0));
    check("mrst_m_tvalid", DW'(m_axis_tvalid), DW'(0));
    check("mrst_m_tlast", DW'(m_axis_tlast), DW'(0));
    check("mrst_m_tdata", m_axis_tdata, DW'(0));
    check("mrst_busy", DW'(busy), DW'(0));
    check("mrst_done", DW'(done), DW'(0));
    check("mrst_overflow", DW'(overflow), DW'(0));
    resetn        = 1'b1;
    m_axis_tready = 1'b1;
    step();
    check("post_s_tready", DW'(s_axis_tready), DW'(1));
    check("post_busy", DW'(busy), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_s2mm_data_framer.md
AXIS_S2MM_DATA_FRAMER -- requirements
Module: axis_s2mm_data_framer

Interface
REQ-001 Parameter DATA_WIDTH, default 128: stream width in bits; a multiple of 8.
REQ-002 Parameter MAX_BURST_LEN, default 512: bytes per DataMover S2MM command; a multiple of DATA_WIDTH/8.
REQ-003 clk  in  1  clock; all logic is on the rising edge.
REQ-004 resetn  in  1  reset, synchronous, active-low.
REQ-005 s_axis_tdata  in  DATA_WIDTH  free-running ADC sample stream.
REQ-006 s_axis_tvalid  in  1  sample valid.
REQ-007 s_axis_tready  out  1  framer can accept a beat.
REQ-008 m_axis_tdata  out  DATA_WIDTH  data to the DataMover S2MM data port.
REQ-009 m_axis_tvalid  out  1  output valid.
REQ-010 m_axis_tready  in  1  DataMover ready.
REQ-011 m_axis_tlast  out  1  last beat of a burst.
REQ-012 m_axis_tkeep  out  DATA_WIDTH/8  constant all-ones.
REQ-013 write_start  in  1  single-cycle pulse; starts a capture.
REQ-014 write_reset  in  1  synchronous soft abort.
REQ-015 cap_size  in  32  capture length in bytes; sampled on write_start.
REQ-016 busy  out  1  a capture is in progress.
REQ-017 done  out  1  single-cycle pulse when the final beat is transferred out.
REQ-018 overflow  out  1  sticky flag: a sample was dropped.

Function
REQ-019 BPB = DATA_WIDTH/8 and BURST_BEATS = MAX_BURST_LEN/BPB; total_beats = cap_size >> log2(BPB), truncating any partial trailing beat.
REQ-020 The state machine SHALL have the states IDLE, STREAM, DRAIN and DONE.
REQ-021 IDLE: s_axis_tready=1, and accepted beats are discarded. On write_start with total_beats>0, the block latches remaining_beats and loads burst_cnt=min(remaining,BURST_BEATS)-1, then goes to STREAM. On write_start with total_beats=0, it goes to DONE.
REQ-022 STREAM: s_axis_tready = skid buffer not full. Each accepted beat enters the buffer tagged with last=(burst_cnt==0). When burst_cnt is 0, burst_cnt reloads with min(remaining-1,BURST_BEATS)-1. Otherwise burst_cnt decrements. remaining decrements on every accepted beat.
REQ-023 STREAM: when the final beat (remaining==1) is accepted, the block goes to DRAIN.
REQ-024 DRAIN: s_axis_tready=0. When the buffer is empty, the block goes to DONE.
REQ-025 DONE: done=1 for exactly one cycle, then the block returns to IDLE.
REQ-026 busy=1 in STREAM and DRAIN only.
REQ-027 The output is a 2-entry skid buffer. m_axis_tvalid follows a STREAM accept by exactly 1 cycle when the buffer is empty. Once m_axis_tvalid is high, m_axis_tdata and m_axis_tlast hold stable until m_axis_tready is high.
REQ-028 In STREAM, if s_axis_tvalid=1 while the buffer is full, the beat is dropped (not counted) and overflow is set. overflow clears only on resetn, or on write_start when busy=0.
REQ-029 Burst boundaries SHALL match the sizes issued by the S2MM command generator from the same cap_size: full MAX_BURST_LEN bursts, then one remainder burst.
REQ-030 write_reset has priority over write_start and over all states. It flushes the buffer, drives m_axis_tvalid=0, goes to IDLE, and produces no done pulse.
REQ-031 write_start while busy=1 SHALL be ignored.
REQ-032 All counters are 32-bit unsigned and never wrap.

Reset
REQ-033 On resetn=0: state=IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, done=0, overflow=0, counters=0, buffer empty.
REQ-034 During reset, s_axis_tready SHALL be 0.

Structure
REQ-035 The state encoding and the BPB/BURST_BEATS derivation belong in the shared package rfsoc_cap_pkg, alongside the command-generator constants.
REQ-036 The skid buffer is the sub-module axis_skid_buf, parameterized by width; it carries {tlast, tdata}.

Verification
REQ-037 cap_size=2048 with continuous tvalid and tready=1: 128 beats out, tlast on beats 32/64/96/128, one done pulse, overflow=0.
REQ-038 cap_size=600: 37 beats out, tlast on beats 32 and 37 (burst sizes 512 and 80 bytes); the trailing 8 bytes are ignored.
REQ-039 cap_size=0: done pulses 2 cycles after write_start, no output beats, busy stays 0.
REQ-040 m_axis_tready low for 5 cycles mid-burst with continuous tvalid: overflow=1, dropped beats are not counted, and the output data and tlast hold stable while stalled.
REQ-041 write_reset asserted at beat 10 of 128: m_axis_tvalid=0 on the next cycle, busy=0, no done pulse; a following write_start with cap_size=512 gives 32 beats with tlast on beat 32.
REQ-042 resetn asserted during STREAM: all outputs return to their REQ-033 values on the next edge.
